// File: rtl/pll_status_monitor.sv
// pll_status_monitor: synchronizes raw PLL lock/counter flags, qualifies lock, counts losses, checks counter activity.
// Optional: define PLL_STATUS_MONITOR_STICKY_FAIL_EN for a sticky O_FAIL that also latches on lock loss.
module pll_status_monitor #(
    parameter int CNT_WIDTH     = 6,
    parameter int STABLE_CYCLES = 1024,
    parameter int WINDOW_LOG2   = 16,
    parameter int LOSS_WIDTH    = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  I_LOCKED,
    input  logic [CNT_WIDTH-1:0]  I_CNT,
    input  logic                  I_CLR,
    output logic                  O_LOCKED_STABLE,
    output logic [CNT_WIDTH-1:0]  O_ALIVE,
    output logic                  O_WIN_VALID,
    output logic                  O_FAIL,
    output logic [LOSS_WIDTH-1:0] O_LOSS_CNT
);
    localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;

    typedef enum logic [1:0] {UNLOCKED, SETTLE, LOCKED} state_t;

    state_t                state_q, state_d;
    logic                  lock_meta_q, lock_s_q;
    logic [CNT_WIDTH-1:0]  cnt_meta_q, cnt_s_q, cnt_dly_q;
    logic [SW-1:0]         settle_q, settle_d;
    logic [WINDOW_LOG2-1:0] win_q, win_d;
    logic [CNT_WIDTH-1:0]  seen_q, seen_d, alive_q, alive_d;
    logic                  valid_q, valid_d, fail_q, fail_d, stable_q, stable_d;
    logic [LOSS_WIDTH-1:0] loss_q, loss_d;
    logic                  in_lock, loss_ev, tc, bad;
    logic [CNT_WIDTH-1:0]  edge_w;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= UNLOCKED;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            cnt_meta_q  <= '0;
            cnt_s_q     <= '0;
            cnt_dly_q   <= '0;
            settle_q    <= '0;
            win_q       <= '0;
            seen_q      <= '0;
            alive_q     <= '0;
            valid_q     <= 1'b0;
            fail_q      <= 1'b0;
            stable_q    <= 1'b0;
            loss_q      <= '0;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= I_LOCKED;
            lock_s_q    <= lock_meta_q;
            cnt_meta_q  <= I_CNT;
            cnt_s_q     <= cnt_meta_q;
            cnt_dly_q   <= cnt_s_q;
            settle_q    <= settle_d;
            win_q       <= win_d;
            seen_q      <= seen_d;
            alive_q     <= alive_d;
            valid_q     <= valid_d;
            fail_q      <= fail_d;
            stable_q    <= stable_d;
            loss_q      <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNLOCKED: state_d = lock_s_q ? SETTLE : UNLOCKED;
            SETTLE:   state_d = !lock_s_q ? UNLOCKED :
                                (settle_q == SW'(STABLE_CYCLES - 2)) ? LOCKED : SETTLE;
            LOCKED:   state_d = lock_s_q ? LOCKED : UNLOCKED;
            default:  state_d = UNLOCKED;
        endcase
    end

    // A lock drop on the terminal cycle suppresses the window result (tc requires lock_s_q).
    always_comb begin
        in_lock  = state_q == LOCKED;
        loss_ev  = in_lock && !lock_s_q;
        tc       = in_lock && lock_s_q && (&win_q);
        edge_w   = cnt_s_q ^ cnt_dly_q;
        settle_d = (state_q == SETTLE && lock_s_q) ? settle_q + SW'(1) : '0;
        win_d    = (in_lock && lock_s_q) ? win_q + WINDOW_LOG2'(1) : '0;
        seen_d   = (!in_lock || loss_ev || tc) ? '0 : (seen_q | edge_w);
        alive_d  = tc ? (seen_q | edge_w) : loss_ev ? '0 : alive_q;
        bad      = ~&(seen_q | edge_w);
        valid_d  = tc;
        stable_d = state_d == LOCKED;
        loss_d   = I_CLR ? '0 : (loss_ev && !(&loss_q)) ? loss_q + LOSS_WIDTH'(1) : loss_q;
`ifdef PLL_STATUS_MONITOR_STICKY_FAIL_EN
        fail_d   = tc ? (bad || (fail_q && !I_CLR)) : loss_ev ? 1'b1 : I_CLR ? 1'b0 : fail_q;
`else
        fail_d   = tc ? bad : (loss_ev || I_CLR) ? 1'b0 : fail_q;
`endif
    end

    assign O_LOCKED_STABLE = stable_q;
    assign O_ALIVE         = alive_q;
    assign O_WIN_VALID     = valid_q;
    assign O_FAIL          = fail_q;
    assign O_LOSS_CNT      = loss_q;
endmodule

// File: tb/tb_pll_status_monitor.sv
// tb_pll_status_monitor: directed bench for pll_status_monitor (STABLE_CYCLES=8, WINDOW_LOG2=4, CNT_WIDTH=6).
module tb_pll_status_monitor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b1;
    logic [5:0] cnt = 6'h2A;
    logic [5:0] mask = 6'h3F;
    logic       clr = 1'b0;
    logic       stable, win_valid, fail;
    logic [5:0] alive;
    logic [7:0] loss;
    int         errs = 0;
    int         checks = 0;
    int         gap;
    logic       seen_flag;

    pll_status_monitor #(.CNT_WIDTH(6), .STABLE_CYCLES(8), .WINDOW_LOG2(4), .LOSS_WIDTH(8)) dut (
        .CLK(clk), .RST_N(rst_n), .I_LOCKED(locked), .I_CNT(cnt), .I_CLR(clr),
        .O_LOCKED_STABLE(stable), .O_ALIVE(alive), .O_WIN_VALID(win_valid),
        .O_FAIL(fail), .O_LOSS_CNT(loss)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every set bit of mask toggles once per cycle; sampling and driving happen 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cnt = cnt ^ mask;
    endtask

    task automatic wait_win(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!win_valid && n < 40);
        check("win_seen", win_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_stable", stable, 0);
        check("rst_alive", alive, 0);
        check("rst_valid", win_valid, 0);
        check("rst_fail", fail, 0);
        check("rst_loss", loss, 0);
        rst_n = 1'b1;
        repeat (9) tick();
        check("rise_early", stable, 0);
        tick();
        check("rise_at_10", stable, 1);

        wait_win(gap);
        check("first_win_gap", gap, 16);
        check("healthy_alive", alive, 6'h3F);
        check("healthy_fail", fail, 0);
        wait_win(gap);
        check("win_period", gap, 16);
        check("healthy_alive2", alive, 6'h3F);

        mask = 6'h1F;
        cnt = cnt & 6'h1F;
        wait_win(gap);
        wait_win(gap);
        check("dead_alive", alive, 6'h1F);
        check("dead_fail", fail, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_fail", fail, 0);
        repeat (14) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_vs_win_valid", win_valid, 1);
        check("clr_vs_win_fail", fail, 1);

        mask = 6'h3F;
        wait_win(gap);
        wait_win(gap);
        check("restore_alive", alive, 6'h3F);
        check("restore_fail", fail, 0);

        seen_flag = 1'b0;
        repeat (7) tick();
        locked = 1'b0;
        repeat (2) begin tick(); seen_flag |= win_valid; end
        check("fall_early", stable, 1);
        tick();
        seen_flag |= win_valid;
        check("fall_at_3", stable, 0);
        check("midloss_alive", alive, 0);
        check("midloss_loss", loss, 1);
        check("midloss_fail", fail, 0);
        repeat (20) begin tick(); seen_flag |= win_valid; end
        check("midloss_no_valid", seen_flag, 0);

        seen_flag = 1'b0;
        locked = 1'b1;
        repeat (5) begin tick(); seen_flag |= stable; end
        locked = 1'b0;
        repeat (3) begin tick(); seen_flag |= stable; end
        locked = 1'b1;
        repeat (9) begin tick(); seen_flag |= stable; end
        check("glitch_no_stable", seen_flag, 0);
        tick();
        check("glitch_resume_rise", stable, 1);
        check("glitch_loss", loss, 1);

        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            repeat (3) tick();
            locked = 1'b1;
            repeat (10) tick();
            if (i == 252) check("loss_fe", loss, 8'hFE);
        end
        check("loss_sat", loss, 8'hFF);
        check("loop_stable", stable, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_loss", loss, 0);

        locked = 1'b0;
        repeat (3) tick();
        locked = 1'b1;
        repeat (10) tick();
        check("loss_one", loss, 1);
        locked = 1'b0;
        repeat (2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_with_loss", loss, 0);
        check("clr_with_loss_stable", stable, 0);
        check("clr_with_loss_fail", fail, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
